// File: rtl/md_div_ctrl.sv
// md_div_ctrl: iterative restoring-division sequencer for DIV/DIVU/REM/REMU.
// Operands are made positive, divided one quotient bit per cycle, and the
// result sign is fixed up at the end. All add/subtract work goes through an
// external shared ALU, so only one adder exists for the whole MDU.

`ifndef MD_ALU_ADD
`define MD_ALU_ADD 2'b00
`endif
`ifndef MD_ALU_SUB
`define MD_ALU_SUB 2'b01
`endif

module md_div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    // request side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    // response side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    // shared ALU
    output logic [1:0]      md_alu_op,
    output logic [XLEN-1:0] md_alu_in_1,
    output logic [XLEN-1:0] md_alu_in_2,
    input  logic [XLEN-1:0] md_alu_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    state_t            state, state_d;

    // latched request
    logic              is_rem;   // in_op[1]: remainder requested
    logic              sgn;      // signed variant (DIV/REM)
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;

    // division working registers
    logic [XLEN-1:0]   ub;       // |divisor|
    logic [XLEN-1:0]   quo;      // dividend shifting out / quotient shifting in
    logic [XLEN-1:0]   rem;      // partial remainder
    logic [CNT_W-1:0]  cnt;

    // request classification, evaluated on the incoming operands
    logic              div_zero;
    logic              sgn_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    // iteration and fix-up helpers
    logic [XLEN-1:0]   shifted;
    logic              ge;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_sel;

    assign div_zero    = (in_b == '0);
    assign sgn_ovf     = ~in_op[0] && (in_a == INT_MIN) && (in_b == ALL_ONE);
    assign special     = div_zero || sgn_ovf;
    // Divide-by-zero takes priority; overflow only reachable with b = -1.
    assign special_res = div_zero ? (in_op[1] ? in_a : ALL_ONE)
                                  : (in_op[1] ? '0   : INT_MIN);

    // The ALU has no borrow-out, so the trial compare is done locally. A set
    // rem MSB means the shifted-out bit makes the 33-bit value exceed ub.
    assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};
    assign ge      = rem[XLEN-1] | (shifted >= ub);

    // Quotient sign follows the operand sign mismatch; remainder follows a.
    assign fix_neg = is_rem ? (sgn & a_q[XLEN-1])
                            : (sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]));
    assign fix_sel = is_rem ? rem : quo;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state and ALU operand selection
    always_comb begin
        state_d     = state;
        md_alu_op   = `MD_ALU_ADD;
        md_alu_in_1 = '0;
        md_alu_in_2 = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) state_d = special ? S_DONE : S_NEG_A;
            end
            S_NEG_A: begin
                md_alu_op   = `MD_ALU_SUB;
                md_alu_in_2 = a_q;
                state_d     = S_NEG_B;
            end
            S_NEG_B: begin
                md_alu_op   = `MD_ALU_SUB;
                md_alu_in_2 = b_q;
                state_d     = S_ITER;
            end
            S_ITER: begin
                md_alu_op   = `MD_ALU_SUB;
                md_alu_in_1 = shifted;
                md_alu_in_2 = ub;
                if (cnt == '0) state_d = S_FIX;
            end
            S_FIX: begin
                md_alu_op   = `MD_ALU_SUB;
                md_alu_in_2 = fix_sel;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers and response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_rem     <= 1'b0;
            sgn        <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ub         <= '0;
            quo        <= '0;
            rem        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        is_rem <= in_op[1];
                        sgn    <= ~in_op[0];
                        a_q    <= in_a;
                        b_q    <= in_b;
                        if (special) begin
                            out_result <= special_res;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                S_NEG_A: begin
                    quo <= (sgn && a_q[XLEN-1]) ? md_alu_out : a_q;
                    rem <= '0;
                end
                S_NEG_B: begin
                    ub  <= (sgn && b_q[XLEN-1]) ? md_alu_out : b_q;
                    cnt <= CNT_W'(XLEN - 1);
                end
                S_ITER: begin
                    rem <= ge ? md_alu_out : shifted;
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    out_result <= fix_neg ? md_alu_out : fix_sel;
                    out_valid  <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_div_ctrl.sv
// tb_md_div_ctrl: self-checking bench for md_div_ctrl with a behavioural ALU
// and a reference model built from plain integer division rules.

`ifndef MD_ALU_ADD
`define MD_ALU_ADD 2'b00
`endif
`ifndef MD_ALU_SUB
`define MD_ALU_SUB 2'b01
`endif

module tb_md_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;
    logic [1:0]  md_alu_op;
    logic [31:0] md_alu_in_1;
    logic [31:0] md_alu_in_2;
    logic [31:0] md_alu_out;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    md_div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy),
        .md_alu_op(md_alu_op), .md_alu_in_1(md_alu_in_1),
        .md_alu_in_2(md_alu_in_2), .md_alu_out(md_alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign md_alu_out = (md_alu_op == `MD_ALU_SUB) ? (md_alu_in_1 - md_alu_in_2)
                                                   : (md_alu_in_1 + md_alu_in_2);

    // RISC-V M-extension division semantics
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return op[1] ? r[31:0] : q[31:0];
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 36;
    endfunction

    // Issue one request and collect its result. lat counts falling edges
    // after the accept edge until out_valid is seen (100 means timed out).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        res = out_result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_busy: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
        tests_run++;
        if (out_valid !== 1'b0 || out_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: out_valid=%b out_result=%h, required 0/0", out_valid, out_result);
        end
        tests_run++;
        if (md_alu_op !== `MD_ALU_ADD || md_alu_in_1 !== 32'd0 || md_alu_in_2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_alu_idle: op=%b in1=%h in2=%h, required ADD/0/0", md_alu_op, md_alu_in_1, md_alu_in_2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] as  [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] bs  [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'h8000_0001,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
        int          elat[10] = '{36, 36, 36, 36, 36, 1, 1, 1, 1, 36};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 10; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat);
            tests_run++;
            if (res !== exp[i]) begin
                tests_failed++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, exp[i]);
            end
            tests_run++;
            if (lat !== elat[i]) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, elat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] picks [6] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3};
        logic [1:0]  op;
        logic [31:0] a, b, res, er;
        int lat, el;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = picks[$urandom_range(0, 5)];
                1:       b = 32'($urandom_range(1, 300));
                default: b = 32'($urandom);
            endcase
            er = ref_result(op, a, b);
            el = ref_latency(op, a, b);
            do_op(op, a, b, res, lat);
            tests_run++;
            if (res !== er || lat !== el) begin
                tests_failed++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, op, a, b, res, lat, er, el);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        tests_run++;
        if (!out_valid) begin
            tests_failed++;
            $display("FAIL bp_timeout: out_valid never rose within 100 cycles");
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2); in_op = OP_DIV; in_a = $urandom; in_b = 32'd1;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== 32'd142 || in_ready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d bad cycles, required out_valid=1 result=0000008e in_ready=0", bad);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_handshake_ready: in_ready=%b during handshake, required 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, required 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat;
        int seen = 0;
        do_op(OP_DIVU, 32'd100, 32'd7, res, lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'h0000_FFFF; in_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);   // now in the tenth ITER cycle
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: busy=%b out_valid=%b out_result=%h in_ready=%b, required 0/0/0/1",
                     busy, out_valid, out_result, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        do_op(OP_DIVU, 32'd9, 32'd3, res, lat);
        tests_run++;
        if (res !== 32'd3 || lat !== 36) begin
            tests_failed++;
            $display("FAIL mid_reset_fresh: got %h lat %0d, required 00000003 lat 36", res, lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
